// File: rtl/pixel_stream_sequencer.sv
// Frame sequencer for the 2bpp image path: fetches packed ROM words, walks the
// pixel indices through the palette and emits an RGB565 valid/ready stream.
module pixel_stream_sequencer #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 144,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic [1:0]        o_color,
    input  logic [4:0]        i_red,
    input  logic [5:0]        i_green,
    input  logic [4:0]        i_blue,
    output logic [15:0]       o_pixel,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sof,
    output logic              o_eol
);

    localparam int unsigned X_W = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
    localparam int unsigned Y_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_shreg;
    logic [2:0]       r_slot;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;

    logic w_accept;
    logic w_load;
    logic w_hs;
    logic w_x_last;
    logic w_y_last;
    logic w_word_end;
    logic w_frame_end;
    logic w_done;

    // Palette index is presented combinationally from the top of the shift reg.
    assign o_color = r_shreg[15:14];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_FETCH;
            S_FETCH:  w_next = S_LOAD;
            S_LOAD:   w_next = S_STREAM;
            S_STREAM: if (w_word_end) w_next = w_frame_end ? S_DRAIN : S_FETCH;
            S_DRAIN:  if (w_done) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Control strobes: a pixel is loaded whenever the output slot is free.
    always_comb begin
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_hs        = o_valid && i_ready;
        w_x_last    = (r_x == X_W'(WIDTH - 1));
        w_y_last    = (r_y == Y_W'(HEIGHT - 1));
        case (r_state)
            S_IDLE:   w_accept = i_start;
            S_STREAM: w_load   = !o_valid || i_ready;
            default:  ;
        endcase
        w_word_end  = w_load && (r_slot == 3'd7);
        w_frame_end = w_load && w_x_last && w_y_last;
        w_done      = (r_state == S_DRAIN) && w_hs;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rom_addr <= '0;
            o_pixel    <= '0;
            o_valid    <= 1'b0;
            o_sof      <= 1'b0;
            o_eol      <= 1'b0;
            r_shreg    <= '0;
            r_slot     <= '0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            o_done <= w_done;
            if (w_accept) begin
                o_busy     <= 1'b1;
                o_rom_addr <= '0;
                r_x        <= '0;
                r_y        <= '0;
            end else if (w_done) begin
                o_busy <= 1'b0;
            end

            if (r_state == S_LOAD) begin
                r_shreg <= i_rom_data;
                r_slot  <= '0;
            end

            // Held pixel only retires on a handshake with nothing new to load.
            if (w_load) begin
                o_pixel <= {i_red, i_green, i_blue};
                o_valid <= 1'b1;
                o_sof   <= (r_x == '0) && (r_y == '0);
                o_eol   <= w_x_last;
                r_shreg <= {r_shreg[13:0], 2'b00};
                r_slot  <= r_slot + 3'd1;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
                if (w_word_end && !w_frame_end) o_rom_addr <= o_rom_addr + ADDR_W'(1);
            end else if (w_hs) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
